add_serial: RTL

- Bit-serial, multi-cycle 8-bit adder; the addition counterpart of the combinational subtract path.
- Takes the same packed operand format: first operand in i[15:8], second in i[7:0].
- Produces o = i[15:8] + i[7:0] (mod 2^WIDTH) plus carry-out, one bit per clock, LSB first.
- Sits in the ALU datapath beside the subtractor where area matters more than latency. Also used to check subtract results: (a − b) + b must equal a.

---
 rtl/add_serial.sv | 97 +++++++++
 1 files changed

// File: rtl/add_serial.sv
// Bit-serial WIDTH-bit adder: packed operands {A, B} on i, sum and carry-out
// produced LSB first over WIDTH cycles, with a single-cycle done pulse.
module add_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] i,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   o,
    output logic               cout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, s_sh_q;
    logic             c_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q, done_q, cout_q;
    logic [WIDTH-1:0] o_q;

    logic             sum_bit;
    logic             carry_d;
    logic [WIDTH-1:0] s_sh_d;

    // One full-adder slice; the sum bit enters the sum register from the top.
    always_comb begin
        sum_bit = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
        carry_d = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
        s_sh_d  = {sum_bit, s_sh_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            o_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= i[2*WIDTH-1:WIDTH];
                        b_sh_q  <= i[WIDTH-1:0];
                        s_sh_q  <= '0;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    s_sh_q <= s_sh_d;
                    c_q    <= carry_d;
                    cnt_q  <= cnt_q + CntW'(1);
                    // start is deliberately ignored here: no restart, no resample.
                    if (cnt_q == CntLast) begin
                        o_q     <= s_sh_d;
                        cout_q  <= carry_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StDone;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign o    = o_q;
    assign cout = cout_q;

endmodule
